// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into 32-bit words
// and writes them to consecutive word addresses starting at BASE_ADDR.
module imem_loader #(
    parameter int unsigned IMEM_SZ   = 256,
    parameter int unsigned BASE_ADDR = 0,
    localparam int unsigned WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [10:0]      len_i,
    input  logic             abort_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             byte_ready_o,
    output logic             wr_en_o,
    output logic [WIDTH-1:0] wr_addr_o,
    output logic [WIDTH-1:0] wr_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StFin} state_e;

    localparam logic [11:0]      MaxLen = 12'(IMEM_SZ);
    localparam logic [WIDTH-1:0] Base   = WIDTH'(BASE_ADDR);

    state_e           state_q, state_d;
    logic [10:0]      len_q, len_d;
    logic [10:0]      idx_q, idx_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [23:0]      word_q, word_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if ((len_i != 11'd0) && ({1'b0, len_i} <= MaxLen)) begin
                        len_d   = len_i;
                        idx_d   = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = StRecv;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRecv: begin
                // Abort beats a same-cycle fourth byte; the output registers stay untouched.
                if (abort_i) begin
                    state_d = StIdle;
                end else if (byte_valid_i) begin
                    cnt_d = cnt_q + 2'd1;
                    unique case (cnt_q)
                        2'd0: word_d[7:0]   = byte_data_i;
                        2'd1: word_d[15:8]  = byte_data_i;
                        2'd2: word_d[23:16] = byte_data_i;
                        default: begin
                            data_d  = {byte_data_i, word_q};
                            addr_d  = Base + {19'b0, idx_q, 2'b00};
                            state_d = StWrite;
                        end
                    endcase
                end
            end
            StWrite: begin
                idx_d = idx_q + 11'd1;
                if (abort_i) begin
                    state_d = StIdle;
                end else if (idx_d == len_q) begin
                    state_d = StFin;
                end else begin
                    state_d = StRecv;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign byte_ready_o = (state_q == StRecv);
    assign wr_en_o      = (state_q == StWrite);
    assign done_o       = (state_q == StFin);
    assign busy_o       = (state_q != StIdle);
    assign err_o        = err_q;
    assign wr_addr_o    = addr_q;
    assign wr_data_o    = data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a word/byte-counting reference model.
module tb_imem_loader;

    localparam int unsigned ImemSz = 256;
    localparam int unsigned Base   = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] len = '0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, wr_en, busy, done, err;
    logic [31:0] wr_addr, wr_data;

    imem_loader #(
        .IMEM_SZ  (ImemSz),
        .BASE_ADDR(Base)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .len_i       (len),
        .abort_i     (abort),
        .byte_valid_i(byte_valid),
        .byte_data_i (byte_data),
        .byte_ready_o(byte_ready),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: load in progress, words written so far, bytes of current word,
    // pending action (0 none, 1 write this cycle, 2 done this cycle).
    bit          m_load;
    int          m_len, m_word, m_nb, m_pend;
    bit          m_err;
    logic [31:0] m_addr, m_data;
    logic [7:0]  m_buf [4];

    logic [7:0]  src [0:4095];
    int          nwr, ndone;
    logic [31:0] log_addr [0:1023];
    logic [31:0] log_data [0:1023];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_load = 0; m_len = 0; m_word = 0; m_nb = 0; m_pend = 0; m_err = 0;
        m_addr = '0; m_data = '0;
    endtask

    task automatic model_step(input bit st, input logic [10:0] ln, input bit ab,
                              input bit bv, input logic [7:0] bd);
        if (!m_load) begin
            if (st) begin
                if (ln >= 1 && int'(ln) <= int'(ImemSz)) begin
                    m_load = 1; m_len = int'(ln); m_word = 0; m_nb = 0; m_pend = 0; m_err = 0;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_pend == 2) begin
            m_load = 0; m_pend = 0;
        end else if (m_pend == 1) begin
            m_word++;
            if (ab) begin
                m_load = 0; m_pend = 0;
            end else if (m_word == m_len) begin
                m_pend = 2;
            end else begin
                m_pend = 0;
            end
        end else if (ab) begin
            m_load = 0;
        end else if (bv) begin
            m_buf[m_nb] = bd;
            m_nb++;
            if (m_nb == 4) begin
                m_nb   = 0;
                m_data = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                m_addr = 32'(Base + 4 * m_word);
                m_pend = 1;
            end
        end
    endtask

    task automatic compare();
        chk("busy", 32'(busy), 32'(m_load));
        chk("byte_ready", 32'(byte_ready), 32'(m_load && m_pend == 0));
        chk("wr_en", 32'(wr_en), 32'(m_pend == 1));
        chk("done", 32'(done), 32'(m_pend == 2));
        chk("err", 32'(err), 32'(m_err));
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
        if (wr_en === 1'b1) begin
            if (nwr < 1024) begin
                log_addr[nwr] = wr_addr;
                log_data[nwr] = wr_data;
            end
            nwr++;
        end
        if (done === 1'b1) ndone++;
    endtask

    task automatic cyc(input bit st, input logic [10:0] ln, input bit ab,
                       input bit bv, input logic [7:0] bd);
        start = st; len = ln; abort = ab; byte_valid = bv; byte_data = bd;
        @(posedge clk);
        model_step(st, ln, ab, bv, bd);
        @(negedge clk);
        compare();
    endtask

    task automatic load(input int ln, input int pv, input bit abort3, input int abort_at);
        int n;
        int budget;
        bit bv;
        bit ab;
        logic [7:0] bd;
        n = 0;
        budget = 40 * ln + 50;
        cyc(1'b1, 11'(ln), 1'b0, 1'b0, 8'h00);
        while (m_load && n < budget) begin
            bv = ($urandom_range(99) < pv);
            bd = src[m_word * 4 + m_nb];
            ab = (n == abort_at);
            if (abort3 && m_pend == 0 && m_word == 2 && m_nb == 3) begin
                bv = 1'b1;
                ab = 1'b1;
            end
            cyc($urandom_range(1) == 1, 11'($urandom_range(2047)), ab, bv, bd);
            n++;
        end
        chk("load_finished_in_budget", 32'(m_load), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 11'($urandom_range(2047)), $urandom_range(1) == 1,
                $urandom_range(1) == 1, 8'($urandom));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_addr"}, wr_addr, 32'd0);
        chk({tag, "_data"}, wr_data, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ln;
        model_reset();
        nwr = 0; ndone = 0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Basic load
        src[0] = 8'h13; src[1] = 8'h00; src[2] = 8'h50; src[3] = 8'h00;
        src[4] = 8'h93; src[5] = 8'h00; src[6] = 8'h10; src[7] = 8'h00;
        nwr = 0; ndone = 0;
        load(2, 100, 1'b0, -1);
        chk("basic_nwr", 32'(nwr), 32'd2);
        chk("basic_addr0", log_addr[0], 32'h0);
        chk("basic_data0", log_data[0], 32'h00500013);
        chk("basic_addr1", log_addr[1], 32'h4);
        chk("basic_data1", log_data[1], 32'h00100093);
        chk("basic_done", 32'(ndone), 32'd1);
        chk("basic_busy_after", 32'(busy), 32'd0);

        // Bad lengths
        nwr = 0;
        cyc(1'b1, 11'd0, 1'b0, 1'b1, 8'h55);
        chk("badlen0_err", 32'(err), 32'd1);
        cyc(1'b1, 11'(ImemSz + 1), 1'b0, 1'b1, 8'h55);
        chk("badlen_big_err", 32'(err), 32'd1);
        chk("badlen_busy", 32'(busy), 32'd0);
        idle(4);
        chk("badlen_nwr", 32'(nwr), 32'd0);
        for (int i = 0; i < 4; i++) src[i] = 8'($urandom);
        load(1, 100, 1'b0, -1);
        chk("goodlen_clears_err", 32'(err), 32'd0);

        // Backpressure, gaps, random aborts and ignored starts
        for (int t = 0; t < 10; t++) begin
            ln = $urandom_range(1, 8);
            for (int i = 0; i < 4 * ln; i++) src[i] = 8'($urandom);
            load(ln, $urandom_range(20, 90), 1'b0,
                 ($urandom_range(2) == 0) ? $urandom_range(0, 12 * ln) : -1);
            idle($urandom_range(0, 3));
        end

        // Abort on third word's fourth byte
        for (int i = 0; i < 20; i++) src[i] = 8'($urandom);
        nwr = 0; ndone = 0;
        load(5, 100, 1'b1, -1);
        chk("abort_nwr", 32'(nwr), 32'd2);
        chk("abort_done", 32'(ndone), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        idle(2);

        // Full-depth load
        for (int i = 0; i < 4 * ImemSz; i++) src[i] = 8'($urandom);
        nwr = 0; ndone = 0;
        load(ImemSz, 80, 1'b0, -1);
        chk("full_nwr", 32'(nwr), 32'(ImemSz));
        chk("full_last_addr", log_addr[ImemSz-1], 32'h3FC);
        chk("full_last_data", log_data[ImemSz-1],
            {src[4*ImemSz-1], src[4*ImemSz-2], src[4*ImemSz-3], src[4*ImemSz-4]});
        chk("full_done", 32'(ndone), 32'd1);

        // Reset after five bytes
        for (int i = 0; i < 16; i++) src[i] = 8'($urandom);
        cyc(1'b1, 11'd4, 1'b0, 1'b0, 8'h00);
        for (int n = 0; n < 20 && !(m_word == 1 && m_nb == 1); n++) begin
            cyc(1'b0, 11'd0, 1'b0, 1'b1, src[m_word * 4 + m_nb]);
        end
        chk("pre_reset_word", 32'(m_word * 4 + m_nb), 32'd5);
        #2;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        nwr = 0; ndone = 0;
        for (int i = 0; i < 10; i++) cyc(1'b0, 11'd0, 1'b0, 1'b1, 8'($urandom));
        chk("post_reset_nwr", 32'(nwr), 32'd0);
        chk("post_reset_ndone", 32'(ndone), 32'd0);
        load(2, 60, 1'b0, -1);
        chk("post_reset_load_nwr", 32'(nwr), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMEM_SZ, default 256, instruction memory depth in words; legal values are powers of two from 4 to 1024.
REQ-002 Parameter BASE_ADDR, default 0, byte address of word 0; must be word-aligned.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  begin a load, sampled only in IDLE.
REQ-006 len  in  11  number of words to load, sampled with start.
REQ-007 abort  in  1  cancels a load in progress.
REQ-008 byte_valid  in  1  byte stream valid.
REQ-009 byte_data  in  8  byte stream data.
REQ-010 byte_ready  out  1  loader can accept a byte.
REQ-011 wr_en  out  1  one-cycle instruction memory write strobe.
REQ-012 wr_addr  out  WIDTH  word-aligned byte address of the write.
REQ-013 wr_data  out  WIDTH  instruction word to write (WIDTH = 32 from the shared package).
REQ-014 busy  out  1  load in progress; the core is held off fetch while high.
REQ-015 done  out  1  one-cycle pulse on successful completion.
REQ-016 err  out  1  sticky: last start request was rejected.

Function
REQ-017 FSM states are IDLE, RECV, WRITE and FIN; the reset state is IDLE.
REQ-018 IDLE, start=1, len in 1..IMEM_SZ: latch len, clear word index and byte count, clear err, go to RECV.
REQ-019 IDLE, start=1, len=0 or len>IMEM_SZ: set err, stay in IDLE, produce no writes.
REQ-020 start is ignored in every state other than IDLE.
REQ-021 byte_ready = 1 only in RECV.
REQ-022 A byte is accepted in any cycle where byte_valid and byte_ready are both 1.
REQ-023 Bytes are assembled little-endian: the first byte goes to [7:0] and the fourth byte goes to [31:24].
REQ-024 Acceptance of the fourth byte moves the FSM to WRITE; the byte count wraps to 0.
REQ-025 WRITE lasts exactly one cycle, with:
  - wr_en = 1
  - wr_data = the assembled word
  - wr_addr = BASE_ADDR + 4*word_index
REQ-026 The latency from acceptance of the fourth byte (cycle N) to wr_en is exactly 1 cycle (cycle N+1).
REQ-027 After WRITE, the word index increments:
  - if the new index equals len, go to FIN;
  - otherwise return to RECV.
REQ-028 FIN lasts one cycle with done = 1, then the FSM returns to IDLE.
REQ-029 busy = 1 in RECV, WRITE and FIN.
REQ-030 busy = 0 in IDLE.
REQ-031 abort = 1 in RECV or WRITE: go to IDLE next cycle, with no wr_en in that cycle and no done.
REQ-032 In RECV, abort and a fourth-byte handshake in the same cycle: abort wins and the partial word is discarded.
REQ-033 In WRITE, an abort does not suppress that cycle's write.
REQ-034 abort in IDLE or FIN has no effect.
REQ-035 byte_valid while byte_ready=0 does not consume the byte; the producer holds its data.
REQ-036 The word index is wide enough for IMEM_SZ.
REQ-037 wr_addr never exceeds BASE_ADDR + 4*(IMEM_SZ-1).
REQ-038 A load of len = IMEM_SZ ends exactly at the last word, with no wrap-around.
REQ-039 wr_addr and wr_data hold their last values when wr_en = 0.

Reset
REQ-040 While rst_n = 0, asynchronously force:
  - FSM state = IDLE
  - byte_ready, wr_en, busy, done, err = 0
  - wr_addr, wr_data, word index and byte count = 0
REQ-041 Reset asserted mid-load abandons the load: no further writes and no done pulse.
REQ-042 After rst_n deasserts, start is required before any byte is accepted.

Verification
REQ-043 Basic load:
  - stimulus: start with len=2; bytes 13,00,50,00,93,00,10,00 with byte_valid held high.
  - response: wr_en at addr 0x0 data 0x00500013; wr_en at addr 0x4 data 0x00100093; done pulse one cycle after the second write; busy low after done.
REQ-044 Backpressure and gaps:
  - stimulus: byte_valid toggled randomly.
  - response: identical written words; each wr_en exactly one cycle after its fourth handshake.
REQ-045 Bad length:
  - stimulus: start with len=0, then start with len=IMEM_SZ+1.
  - response: err=1 both times; no wr_en; busy stays 0.
  - follow-up: a subsequent valid start clears err.
REQ-046 Abort:
  - stimulus: abort asserted in the same cycle as the third word's fourth byte.
  - response: only two writes; no done; IDLE next cycle.
REQ-047 Full-depth load:
  - stimulus: len=256, BASE_ADDR=0.
  - response: 256 writes; last write at wr_addr=0x3FC; done once.
REQ-048 Reset mid-load:
  - stimulus: rst_n pulsed low after 5 bytes.
  - response: all outputs 0 immediately (asynchronously); no writes until a new start.
